// File: rtl/round_key_store_pkg.sv
// round_key_store_pkg: AES round-key store sizes, types and wipe FSM state codes
package round_key_store_pkg;
  localparam int NB = 4;
  localparam int NR_128 = 10;
  localparam int NR_256 = 14;
  localparam int DEPTH = NR_256 + 1;
  localparam int KEY_W = 128;
  localparam int IDX_W = NB;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WIPE = 1'b1;
  typedef logic [KEY_W-1:0] round_key_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/round_key_store_if.sv
// round_key_store_if: write/read bus of the round-key store (zeroize only with KEY_STORE_ZEROIZE_EN)
interface round_key_store_if;
  import round_key_store_pkg::*;
  logic wr_start;
  logic wr_en;
  logic wr_last;
  round_key_t wr_key;
  logic key_req;
  idx_t round_key_no;
  round_key_t key;
  logic key_valid;
  logic keys_ready;
  idx_t key_count;
  logic key_err;
  logic busy;
`ifdef KEY_STORE_ZEROIZE_EN
  logic zeroize;
`endif
  modport master (
`ifdef KEY_STORE_ZEROIZE_EN
    output zeroize,
`endif
    output wr_start, wr_en, wr_last, wr_key, key_req, round_key_no,
    input key, key_valid, keys_ready, key_count, key_err, busy
  );
  modport slave (
`ifdef KEY_STORE_ZEROIZE_EN
    input zeroize,
`endif
    input wr_start, wr_en, wr_last, wr_key, key_req, round_key_no,
    output key, key_valid, keys_ready, key_count, key_err, busy
  );
endinterface

// File: rtl/round_key_store_key_sram_1r1w.sv
// key_sram_1r1w: DEPTH x KEY_W 1R1W memory, synchronous read-first with a read register
module key_sram_1r1w #(
  parameter int DEPTH = 15,
  parameter int KEY_W = 128,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [KEY_W-1:0] rdata
);
  logic [KEY_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/round_key_store.sv
// round_key_store: round-key schedule store with 2-cycle reads; KEY_STORE_ZEROIZE_EN adds a wipe FSM
module round_key_store
  import round_key_store_pkg::*;
(
  input logic clk,
  input logic reset,
  round_key_store_if.slave bus
);
  idx_t wr_ptr, ptr_eff, wipe_ptr;
  round_key_t rd_data;
  logic wiping, start_wipe, blocked, wr_ok, wr_err, rd_v, rd_ok;
`ifdef KEY_STORE_ZEROIZE_EN
  logic [0:0] state;
  assign wiping = state == ST_WIPE;
  assign start_wipe = bus.zeroize && !wiping;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wipe_ptr <= '0;
    end else begin
      state <= wiping ? (wipe_ptr == IDX_W'(DEPTH - 1) ? ST_IDLE : ST_WIPE) : (bus.zeroize ? ST_WIPE : ST_IDLE);
      wipe_ptr <= wiping ? wipe_ptr + 1'b1 : '0;
    end
  end
`else
  assign wiping = 1'b0;
  assign start_wipe = 1'b0;
  assign wipe_ptr = '0;
`endif
  assign blocked = wiping || start_wipe;
  assign bus.busy = wiping;
  // wr_start in the same cycle as wr_en restarts the schedule at slot 0
  always_comb begin
    ptr_eff = bus.wr_start ? '0 : wr_ptr;
    wr_ok = bus.wr_en && !blocked && ptr_eff != IDX_W'(DEPTH) && !(bus.keys_ready && !bus.wr_start);
    wr_err = bus.wr_en && !blocked && !wr_ok;
  end
  key_sram_1r1w #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W)) u_sram (
    .clk   (clk),
    .we    (wr_ok || wiping),
    .waddr (wiping ? wipe_ptr : ptr_eff),
    .wdata (wiping ? '0 : bus.wr_key),
    .re    (bus.key_req),
    .raddr (bus.round_key_no),
    .rdata (rd_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      bus.keys_ready <= 1'b0;
      bus.key_count <= '0;
      rd_v <= 1'b0;
      rd_ok <= 1'b0;
      bus.key <= '0;
      bus.key_valid <= 1'b0;
      bus.key_err <= 1'b0;
    end else begin
      if (start_wipe || (bus.wr_start && !blocked)) begin
        wr_ptr <= '0;
        bus.keys_ready <= 1'b0;
        bus.key_count <= '0;
      end
      if (wr_ok) begin
        wr_ptr <= ptr_eff + 1'b1;
        if (bus.wr_last) begin
          bus.keys_ready <= 1'b1;
          bus.key_count <= ptr_eff + 1'b1;
        end
      end
      rd_v <= bus.key_req;
      rd_ok <= bus.key_req && bus.keys_ready && !blocked && bus.round_key_no < bus.key_count;
      bus.key_valid <= rd_v;
      if (rd_v) bus.key <= rd_ok ? rd_data : '0;
      bus.key_err <= wr_err || (rd_v && !rd_ok);
    end
  end
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed bench with a read scoreboard for round_key_store (KEY_STORE_ZEROIZE_EN optional)
module tb_round_key_store;
  import round_key_store_pkg::*;
  typedef struct packed { logic [KEY_W-1:0] key; logic err; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [127:0] k128 [11] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  logic [127:0] k256 [15] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
    128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
    128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
    128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
    128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
    128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
    128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
    128'h24fc79ccbf0979e9371ac23c6d68de36};
  round_key_store_if bus();
  round_key_store dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic s, input logic last, input logic [127:0] k);
    bus.wr_start = s;
    bus.wr_en = 1'b1;
    bus.wr_last = last;
    bus.wr_key = k;
    step();
    bus.wr_start = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_last = 1'b0;
  endtask
  task automatic req(input int idx, input logic [127:0] k, input logic e);
    exp_t x;
    x.key = k;
    x.err = e;
    sb.push_back(x);
    bus.key_req = 1'b1;
    bus.round_key_no = IDX_W'(idx);
    step();
    bus.key_req = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
  endtask
  // every key_valid pulse must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.key_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_key_valid", 128'(bus.key_valid), 128'd0);
      else begin
        e = sb.pop_front();
        chk("read_key", bus.key, e.key);
        chk("read_err", 128'(bus.key_err), 128'(e.err));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] vv;
    int n;
    bus.wr_start = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_last = 1'b0;
    bus.wr_key = '0;
    bus.key_req = 1'b0;
    bus.round_key_no = '0;
`ifdef KEY_STORE_ZEROIZE_EN
    bus.zeroize = 1'b0;
`endif
    step(2);
    chk("rst_key", bus.key, 128'd0);
    chk("rst_key_valid", 128'(bus.key_valid), 128'd0);
    chk("rst_keys_ready", 128'(bus.keys_ready), 128'd0);
    chk("rst_key_count", 128'(bus.key_count), 128'd0);
    chk("rst_key_err", 128'(bus.key_err), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 11; i++) wr(i == 0, i == 10, k128[i]);
    chk("aes128_ready", 128'(bus.keys_ready), 128'd1);
    chk("aes128_count", 128'(bus.key_count), 128'd11);
    req(10, k128[10], 1'b0);
    chk("latency_not_early", 128'(bus.key_valid), 128'd0);
    step();
    chk("latency_two", 128'(bus.key_valid), 128'd1);
    drain();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        exp_t x;
        x.key = k128[10 - i];
        x.err = 1'b0;
        sb.push_back(x);
        bus.key_req = 1'b1;
        bus.round_key_no = IDX_W'(10 - i);
      end else bus.key_req = 1'b0;
      step();
      vv[4 - i] = bus.key_valid;
    end
    chk("b2b_valid_pattern", 128'(vv), 128'b01110);
    drain();
    req(11, 128'd0, 1'b1);
    drain();
    bus.wr_en = 1'b1;
    bus.wr_key = '1;
    step();
    bus.wr_en = 1'b0;
    chk("wr_no_start_err", 128'(bus.key_err), 128'd1);
    step();
    chk("wr_err_pulse_end", 128'(bus.key_err), 128'd0);
    chk("wr_no_start_count", 128'(bus.key_count), 128'd11);
    req(0, k128[0], 1'b0);
    req(10, k128[10], 1'b0);
    drain();
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    chk("start_clears_ready", 128'(bus.keys_ready), 128'd0);
    chk("start_clears_count", 128'(bus.key_count), 128'd0);
    for (int i = 0; i < 15; i++) wr(1'b0, 1'b0, k256[i]);
    chk("full_no_err", 128'(bus.key_err), 128'd0);
    wr(1'b0, 1'b1, '1);
    chk("overflow_err", 128'(bus.key_err), 128'd1);
    chk("overflow_not_ready", 128'(bus.keys_ready), 128'd0);
    for (int i = 0; i < 15; i++) wr(i == 0, i == 14, k256[i]);
    chk("aes256_ready", 128'(bus.keys_ready), 128'd1);
    chk("aes256_count", 128'(bus.key_count), 128'd15);
    req(14, k256[14], 1'b0);
    req(1, k256[1], 1'b0);
    drain();
`ifdef KEY_STORE_ZEROIZE_EN
    bus.zeroize = 1'b1;
    step();
    bus.zeroize = 1'b0;
    chk("wipe_busy", 128'(bus.busy), 128'd1);
    chk("wipe_ready", 128'(bus.keys_ready), 128'd0);
    chk("wipe_count", 128'(bus.key_count), 128'd0);
    begin
      exp_t x;
      x.key = '0;
      x.err = 1'b1;
      sb.push_back(x);
    end
    bus.key_req = 1'b1;
    bus.round_key_no = '0;
    n = 0;
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
      n++;
      step();
      bus.key_req = 1'b0;
    end
    chk("wipe_cycles", 128'(n), 128'd15);
    wr(1'b1, 1'b1, k128[9]);
    chk("reload_count", 128'(bus.key_count), 128'd1);
    req(0, k128[9], 1'b0);
    drain();
    for (int i = 1; i < 15; i++) chk($sformatf("wiped_slot%0d", i), dut.u_sram.mem[i], 128'd0);
`endif
    bus.key_req = 1'b1;
    bus.round_key_no = '0;
    step();
    bus.key_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    vv = '0;
    for (int i = 0; i < 4; i++) begin
      vv[i] = bus.key_valid;
      step();
    end
    chk("reset_drops_read", 128'(vv), 128'd0);
    chk("reset_ready", 128'(bus.keys_ready), 128'd0);
    req(0, 128'd0, 1'b1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
